// File: rtl/core_pipe_pkg.sv
// core_pipe_pkg
//   Shared definitions for the five-stage core pipeline registers:
//   stall-vector bit positions, occupancy state encodings, the action
//   decoded each clock by a stage register, and bundle widths at each
//   stage boundary.
package core_pipe_pkg;

  // Bit positions in the core stall vector. Stall bits are monotone toward
  // earlier stages: if stall[k] is set then so is every stall[j] with j < k.
  localparam int STALL_IF   = 0;
  localparam int STALL_ID   = 1;
  localparam int STALL_EX   = 2;
  localparam int STALL_MEM  = 3;
  localparam int STALL_DMEM = 4;
  localparam int STALL_WB   = 5;

  // Occupancy of a stage register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LIVE  = 2'd1,
    ST_HELD  = 2'd2
  } pipe_state_e;

  // What a stage register does on the coming clock edge.
  typedef enum logic [1:0] {
    ACT_FLUSH  = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_LOAD   = 2'd2,
    ACT_HOLD   = 2'd3
  } stage_act_e;

  // Payload widths of the concatenated bundles at each stage boundary.
  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 108;
  localparam int EX_MEM_W = 108;
  localparam int MEM_WB_W = 72;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter
//   Saturating up-counter used for per-stage performance statistics.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-low reset, clears the count
//     inc  - increment by one (ignored once the count is all-ones)
//     clr  - synchronous clear; wins over inc in the same cycle
//     q    - current count
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Inter-stage pipeline register carrying an opaque DATA_W payload and a
//   valid bit. The upstream stage index STAGE selects up = stall[STAGE] and
//   dn = stall[STAGE+1] (dn = 0 for the last stage).
//
//   Stall contract (single place documenting the handshake):
//     flush          -> kill contents (bubble value, invalid, EMPTY)
//     up && !dn      -> insert bubble (same loads as flush)
//     !up            -> load in_data/in_valid; dn is ignored because stall
//                       bits are monotone toward earlier stages
//     up && dn       -> hold contents; LIVE turns HELD
//   Priority is top to bottom.
//
//   Ports:
//     clk, rst            - clock; asynchronous active-low reset
//     stall[STALL_W]      - core stall vector
//     flush               - synchronous kill of stage contents
//     in_valid, in_data   - upstream payload
//     out_valid, out_data - registered payload
//     out_state           - occupancy: 0 EMPTY, 1 LIVE, 2 HELD
//     cnt_clr             - synchronous clear of all counters
//     bubble_cnt          - bubbles inserted
//     hold_cnt            - cycles a valid payload was held
//     flush_cnt           - flushes that killed a valid payload
module pipe_stage_reg
  import core_pipe_pkg::*;
#(
  parameter int                DATA_W     = 108,
  parameter int                STALL_W    = 6,
  parameter int                STAGE      = 3,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         out_state,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  // The stall vector is extended by a constant-zero bit so that the stage
  // after the last one reads as never stalled, without an out-of-range index.
  localparam logic [STALL_W:0] UP_MASK = (STALL_W + 1)'(1) << STAGE;
  localparam logic [STALL_W:0] DN_MASK = UP_MASK << 1;

  logic [STALL_W:0] stall_ext;
  logic             up;
  logic             dn;

  assign stall_ext = {1'b0, stall};
  assign up        = |(stall_ext & UP_MASK);
  assign dn        = |(stall_ext & DN_MASK);

  pipe_state_e state_q;
  pipe_state_e state_nxt;
  stage_act_e  act;

  // Action decode and occupancy next-state.
  always_comb begin
    act       = ACT_HOLD;
    state_nxt = state_q;
    if (flush) begin
      act       = ACT_FLUSH;
      state_nxt = ST_EMPTY;
    end else if (up && !dn) begin
      act       = ACT_BUBBLE;
      state_nxt = ST_EMPTY;
    end else if (!up) begin
      act       = ACT_LOAD;
      state_nxt = in_valid ? ST_LIVE : ST_EMPTY;
    end else begin
      act       = ACT_HOLD;
      state_nxt = (state_q == ST_LIVE) ? ST_HELD : state_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= BUBBLE_VAL;
    end else begin
      case (act)
        ACT_FLUSH, ACT_BUBBLE: begin
          out_valid <= 1'b0;
          out_data  <= BUBBLE_VAL;
        end
        ACT_LOAD: begin
          out_valid <= in_valid;
          out_data  <= in_data;
        end
        default: begin
          out_valid <= out_valid;
          out_data  <= out_data;
        end
      endcase
    end
  end

  assign out_state = state_q;

  // Counters see only the decoded action, so a flush masks the bubble and
  // hold increments it overrides.
  logic bubble_inc;
  logic hold_inc;
  logic flush_inc;

  assign bubble_inc = (act == ACT_BUBBLE);
  assign hold_inc   = (act == ACT_HOLD) && out_valid;
  assign flush_inc  = (act == ACT_FLUSH) && out_valid;

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bubble_inc),
    .clr (cnt_clr),
    .q   (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hold_inc),
    .clr (cnt_clr),
    .q   (hold_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .clr (cnt_clr),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg. Two instances share stimulus:
//   dut_a has STAGE=3, dut_b is the last stage (STAGE=5); both use 4-bit
//   counters so saturation is reachable.
module tb_pipe_stage_reg;

  localparam int DW = 108;
  localparam int SW = 6;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [SW-1:0] stall    = '0;
  logic          flush    = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          cnt_clr  = 1'b0;

  logic          a_valid, b_valid;
  logic [DW-1:0] a_data, b_data;
  logic [1:0]    a_state, b_state;
  logic [CW-1:0] a_bub, a_hold, a_fl, b_bub, b_hold, b_fl;

  pipe_stage_reg #(.DATA_W(DW), .STALL_W(SW), .STAGE(3), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(a_valid), .out_data(a_data), .out_state(a_state),
    .cnt_clr(cnt_clr), .bubble_cnt(a_bub), .hold_cnt(a_hold), .flush_cnt(a_fl)
  );

  pipe_stage_reg #(.DATA_W(DW), .STALL_W(SW), .STAGE(5), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(b_valid), .out_data(b_data), .out_state(b_state),
    .cnt_clr(cnt_clr), .bubble_cnt(b_bub), .hold_cnt(b_hold), .flush_cnt(b_fl)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are sampled on the next
  // falling edge, one rising edge later.
  task automatic step(input logic [SW-1:0] s, input logic f, input logic v,
                      input logic [DW-1:0] d, input logic c);
    stall = s; flush = f; in_valid = v; in_data = d; cnt_clr = c;
    @(negedge clk);
  endtask

  typedef struct {
    logic [SW-1:0] stall;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          cnt_clr;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [1:0]    e_state;
    logic [CW-1:0] e_bub;
    logic [CW-1:0] e_hold;
    logic [CW-1:0] e_fl;
  } vec_t;

  vec_t vecs[18];
  logic [DW-1:0] pat_a, pat_b, pat_c;

  localparam logic [SW-1:0] S_RUN  = 6'b000000;
  localparam logic [SW-1:0] S_HOLD = 6'b011000;
  localparam logic [SW-1:0] S_BUB  = 6'b001000;
  localparam logic [SW-1:0] S_DN   = 6'b100000;

  initial begin
    pat_a = '0; pat_a[15:0] = 16'hABCD; pat_a[107:100] = 8'hA5;
    pat_b = '0; pat_b[31:0] = 32'h1234_5678; pat_b[107:104] = 4'h9;
    pat_c = '0; pat_c[63:48] = 16'hBEEF; pat_c[3:0] = 4'h7;

    //            stall   fl   v    data   clr  e_v  e_data  st  bub   hold  fl
    vecs[0]  = '{S_RUN,  1'b0, 1'b1, pat_a, 1'b0, 1'b1, pat_a, 2'd1, 4'd0, 4'd0, 4'd0};
    vecs[1]  = '{S_HOLD, 1'b0, 1'b1, pat_b, 1'b0, 1'b1, pat_a, 2'd2, 4'd0, 4'd1, 4'd0};
    vecs[2]  = '{S_HOLD, 1'b0, 1'b1, pat_b, 1'b0, 1'b1, pat_a, 2'd2, 4'd0, 4'd2, 4'd0};
    vecs[3]  = '{S_HOLD, 1'b0, 1'b1, pat_b, 1'b0, 1'b1, pat_a, 2'd2, 4'd0, 4'd3, 4'd0};
    vecs[4]  = '{S_BUB,  1'b0, 1'b1, pat_b, 1'b0, 1'b0, '0,    2'd0, 4'd1, 4'd3, 4'd0};
    vecs[5]  = '{S_RUN,  1'b0, 1'b0, pat_c, 1'b0, 1'b0, pat_c, 2'd0, 4'd1, 4'd3, 4'd0};
    vecs[6]  = '{S_HOLD, 1'b0, 1'b1, pat_a, 1'b0, 1'b0, pat_c, 2'd0, 4'd1, 4'd3, 4'd0};
    vecs[7]  = '{S_RUN,  1'b0, 1'b1, pat_b, 1'b0, 1'b1, pat_b, 2'd1, 4'd1, 4'd3, 4'd0};
    vecs[8]  = '{S_HOLD, 1'b0, 1'b1, pat_a, 1'b0, 1'b1, pat_b, 2'd2, 4'd1, 4'd4, 4'd0};
    vecs[9]  = '{S_HOLD, 1'b1, 1'b1, pat_a, 1'b0, 1'b0, '0,    2'd0, 4'd1, 4'd4, 4'd1};
    vecs[10] = '{S_HOLD, 1'b1, 1'b1, pat_a, 1'b0, 1'b0, '0,    2'd0, 4'd1, 4'd4, 4'd1};
    vecs[11] = '{S_BUB,  1'b1, 1'b1, pat_a, 1'b0, 1'b0, '0,    2'd0, 4'd1, 4'd4, 4'd1};
    vecs[12] = '{S_RUN,  1'b0, 1'b1, pat_a, 1'b0, 1'b1, pat_a, 2'd1, 4'd1, 4'd4, 4'd1};
    vecs[13] = '{S_BUB,  1'b1, 1'b1, pat_b, 1'b0, 1'b0, '0,    2'd0, 4'd1, 4'd4, 4'd2};
    vecs[14] = '{S_RUN,  1'b0, 1'b1, pat_b, 1'b1, 1'b1, pat_b, 2'd1, 4'd0, 4'd0, 4'd0};
    vecs[15] = '{S_DN,   1'b0, 1'b1, pat_c, 1'b0, 1'b1, pat_c, 2'd1, 4'd0, 4'd0, 4'd0};
    vecs[16] = '{S_HOLD, 1'b0, 1'b1, pat_a, 1'b1, 1'b1, pat_c, 2'd2, 4'd0, 4'd0, 4'd0};
    vecs[17] = '{S_HOLD, 1'b0, 1'b1, pat_a, 1'b0, 1'b1, pat_c, 2'd2, 4'd0, 4'd1, 4'd0};
  end

  // ---------------- test ----------------
  initial begin
    #2;
    chk("reset_valid", DW'(a_valid), DW'(0));
    chk("reset_data", a_data, '0);
    chk("reset_state", DW'(a_state), DW'(0));
    chk("reset_bub", DW'(a_bub), DW'(0));

    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].stall, vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].cnt_clr);
      chk($sformatf("v%0d_valid", i), DW'(a_valid), DW'(vecs[i].e_valid));
      chk($sformatf("v%0d_data", i), a_data, vecs[i].e_data);
      chk($sformatf("v%0d_state", i), DW'(a_state), DW'(vecs[i].e_state));
      chk($sformatf("v%0d_bub", i), DW'(a_bub), DW'(vecs[i].e_bub));
      chk($sformatf("v%0d_hold", i), DW'(a_hold), DW'(vecs[i].e_hold));
      chk($sformatf("v%0d_flush", i), DW'(a_fl), DW'(vecs[i].e_fl));
    end

    // Hold saturation: hold_cnt is 1 here, 20 more hold edges pin it at 15.
    for (int i = 0; i < 20; i++) step(S_HOLD, 1'b0, 1'b1, pat_b, 1'b0);
    chk("sat_hold", DW'(a_hold), DW'(15));
    chk("sat_data", a_data, pat_c);
    chk("sat_state", DW'(a_state), DW'(2));

    // Clear on a hold edge gives 0, not 1; datapath untouched.
    step(S_HOLD, 1'b0, 1'b1, pat_b, 1'b1);
    chk("clr_hold", DW'(a_hold), DW'(0));
    chk("clr_state", DW'(a_state), DW'(2));
    step(S_HOLD, 1'b0, 1'b1, pat_b, 1'b0);
    chk("post_clr_hold", DW'(a_hold), DW'(1));

    // Asynchronous reset mid-cycle while HELD and valid.
    rst = 1'b0;
    #1;
    chk("areset_valid", DW'(a_valid), DW'(0));
    chk("areset_data", a_data, '0);
    chk("areset_state", DW'(a_state), DW'(0));
    chk("areset_hold", DW'(a_hold), DW'(0));
    chk("areset_b_bub", DW'(b_bub), DW'(0));
    @(negedge clk);
    rst = 1'b1;

    // Last stage: stall[5] alone is a bubble for STAGE=5, a load for STAGE=3.
    step(S_RUN, 1'b0, 1'b1, pat_a, 1'b0);
    chk("top_load_valid", DW'(b_valid), DW'(1));
    chk("top_load_data", b_data, pat_a);
    step(S_DN, 1'b0, 1'b1, pat_b, 1'b0);
    chk("top_valid", DW'(b_valid), DW'(0));
    chk("top_data", b_data, '0);
    chk("top_state", DW'(b_state), DW'(0));
    chk("top_bub", DW'(b_bub), DW'(1));
    chk("top_hold", DW'(b_hold), DW'(0));
    chk("mid_dn_ignored_data", a_data, pat_b);
    chk("mid_dn_ignored_state", DW'(a_state), DW'(1));

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
